// File: rtl/cadre_frame.sv
// Draws a THICK-pixel border just inside the visible area and uses the background colour everywhere else.
// Output is registered, so there is one cycle of latency from hpos/vpos to couleur.
module cadre_frame #(
  parameter int unsigned H_START     = 112,
  parameter int unsigned V_START     = 12,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned THICK       = 3,
  parameter int unsigned FRAME_COLOR = 24,
  parameter int unsigned BG_COLOR    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  output logic [4:0]  couleur
);

  // Bounds use 12 bits so the sums cannot wrap for legal parameter values.
  localparam logic [11:0] H_FIRST  = 12'(H_START);
  localparam logic [11:0] H_LAST   = 12'(H_START + H_ACTIVE - 1);
  localparam logic [11:0] H_IN_END = 12'(H_START + THICK);
  localparam logic [11:0] H_IN_BEG = 12'(H_START + H_ACTIVE - THICK);
  localparam logic [11:0] V_FIRST  = 12'(V_START);
  localparam logic [11:0] V_LAST   = 12'(V_START + V_ACTIVE - 1);
  localparam logic [11:0] V_IN_END = 12'(V_START + THICK);
  localparam logic [11:0] V_IN_BEG = 12'(V_START + V_ACTIVE - THICK);

  localparam logic [4:0] FRAME_C = 5'(FRAME_COLOR);
  localparam logic [4:0] BG_C    = 5'(BG_COLOR);

  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic        in_visible;
  logic        in_band;
  logic [4:0]  couleur_d;
  logic [4:0]  couleur_q;

  assign h_ext = {1'b0, hpos};
  assign v_ext = {1'b0, vpos};

  // Classify the current pixel and pick its colour.
  always_comb begin
    couleur_d  = BG_C;
    in_visible = (h_ext >= H_FIRST) && (h_ext <= H_LAST) &&
                 (v_ext >= V_FIRST) && (v_ext <= V_LAST);
    in_band    = (h_ext < H_IN_END) || (h_ext >= H_IN_BEG) ||
                 (v_ext < V_IN_END) || (v_ext >= V_IN_BEG);
    if (in_visible && in_band) begin
      couleur_d = FRAME_C;
    end else begin
      couleur_d = BG_C;
    end
  end

  // Output register; reset forces background immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      couleur_q <= BG_C;
    end else begin
      couleur_q <= couleur_d;
    end
  end

  assign couleur = couleur_q;

endmodule

// File: tb/tb_cadre_frame.sv
// Directed bench for cadre_frame: expected colours queued on stimulus, checked one clock later.
module tb_cadre_frame;

  logic        clk;
  logic        rst;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic [4:0]  couleur;

  int n_checks;
  int n_fails;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  cadre_frame dut (
    .clk     (clk),
    .rst     (rst),
    .hpos    (hpos),
    .vpos    (vpos),
    .couleur (couleur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_now(input string tag, input logic [4:0] expected);
    n_checks++;
    assert (couleur === expected) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, couleur, expected);
    end
  endtask

  task automatic pop_check();
    logic [4:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL scoreboard_empty: observed %0d expected none", couleur);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_now(t, e);
    end
  endtask

  // Drive one pixel, queue its colour, and check it after the next rising edge.
  task automatic step(input logic [10:0] h, input logic [10:0] v,
                      input logic [4:0] expected, input string tag);
    hpos = h;
    vpos = v;
    exp_q.push_back(expected);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst  = 1'b0;
    hpos = 11'd112;
    vpos = 11'd212;

    #2 rst = 1'b1;
    #1 check_now("reset_async_start", 5'd0);
    repeat (3) @(posedge clk);
    #1 check_now("reset_hold_start", 5'd0);
    @(negedge clk) rst = 1'b0;
    #1;

    step(11'd112, 11'd212, 5'd24, "left_first");
    step(11'd114, 11'd212, 5'd24, "left_last");
    step(11'd115, 11'd212, 5'd0,  "left_inside");
    step(11'd749, 11'd212, 5'd24, "right_first");
    step(11'd751, 11'd212, 5'd24, "right_last");
    step(11'd752, 11'd212, 5'd0,  "right_outside");
    step(11'd751, 11'd491, 5'd24, "bottom_last");
    step(11'd751, 11'd492, 5'd0,  "bottom_outside");
    step(11'd412, 11'd489, 5'd24, "bottom_first");
    step(11'd412, 11'd488, 5'd0,  "bottom_inside");
    step(11'd412, 11'd12,  5'd24, "top_first");
    step(11'd412, 11'd14,  5'd24, "top_last");
    step(11'd412, 11'd15,  5'd0,  "top_inside");
    step(11'd751, 11'd12,  5'd24, "corner_tr");
    step(11'd112, 11'd491, 5'd24, "corner_bl");
    step(11'd0,   11'd0,   5'd0,  "blank_origin");
    step(11'd111, 11'd212, 5'd0,  "blank_left");
    step(11'd412, 11'd11,  5'd0,  "blank_top");
    step(11'd412, 11'd250, 5'd0,  "interior");
    step(11'd2047, 11'd2047, 5'd0, "max_inputs");
    step(11'd112, 11'd12,  5'd24, "corner_tl");

    // Input wiggle between edges must not reach the output before the next edge.
    hpos = 11'd412;
    vpos = 11'd250;
    #2 check_now("no_edge_change", 5'd24);
    @(negedge clk);
    step(11'd112, 11'd212, 5'd24, "pre_reset");

    #2 rst = 1'b1;
    #1 check_now("reset_async_mid", 5'd0);
    repeat (3) @(posedge clk);
    #1 check_now("reset_hold_mid", 5'd0);
    @(negedge clk) rst = 1'b0;
    #1 check_now("reset_release_no_edge", 5'd0);
    exp_q.push_back(5'd24);
    tag_q.push_back("reset_release_edge");
    @(posedge clk);
    #1 pop_check();

    step(11'd300, 11'd300, 5'd0, "after_reset_interior");

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fails++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
